// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM arbiter: FSM states, access owners, idle control levels.
package sram_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_RD       = 3'd1,
    ARB_WR_SETUP = 3'd2,
    ARB_WR_PULSE = 3'd3,
    ARB_WR_HOLD  = 3'd4
  } arb_state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam logic [3:0] CTRL_OFF = 4'b1111;

endpackage

// File: rtl/sram_fetch_buf.sv
// One-entry fetch buffer (tag = word address, data); only built with SRAM_ARB_FETCH_BUF_EN.
`ifdef SRAM_ARB_FETCH_BUF_EN
module sram_fetch_buf
  import sram_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookup_tag,
  input  logic        fill_en,
  input  logic [29:0] fill_tag,
  input  logic [31:0] fill_data,
  input  logic        inval_en,
  input  logic [29:0] inval_tag,
  output logic        hit,
  output logic [31:0] data
);

  logic        valid_q;
  logic [29:0] tag_q;
  logic [31:0] data_q;

  assign hit  = valid_q && (tag_q == lookup_tag);
  assign data = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag;
      data_q  <= fill_data;
    end else if (inval_en && (inval_tag == tag_q)) begin
      valid_q <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/sram_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one 32-bit SRAM with multi-cycle timing.
// Optional fetch buffer enabled by defining SRAM_ARB_FETCH_BUF_EN.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2,
  parameter int SRAM_AW   = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req_i,
  input  logic [31:0]        if_addr_i,
  output logic [31:0]        if_data_o,
  output logic               if_ready_o,
  input  logic               mem_ce_n_i,
  input  logic               mem_we_n_i,
  input  logic               mem_oe_n_i,
  input  logic [3:0]         mem_be_n_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        mem_wdata_i,
  output logic [31:0]        mem_rdata_o,
  output logic               mem_ready_o,
  output logic               stall_req_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_wdata_o,
  input  logic [31:0]        sram_rdata_i,
  output logic               sram_data_oe_o,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o,
  output logic [3:0]         sram_be_n_o
);

  localparam logic [2:0] RD_LAST = 3'(RD_CYCLES - 1);
  localparam logic [2:0] WR_LAST = 3'(WR_CYCLES - 1);

  arb_state_t         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               owner_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic [31:0]        if_data_q, mem_rdata_q;
  logic               if_ready_q, mem_ready_q;
  logic               mem_req, mem_wr, rd_done, wr_done;
  logic               accept_wr, accept_mem, accept_if, fetch_hit;
  logic               buf_hit;
  logic [31:0]        buf_data;
  logic               unused_addr_bits;

  assign mem_req = !mem_ce_n_i && (!mem_we_n_i || !mem_oe_n_i);
  assign mem_wr  = mem_req && !mem_we_n_i;
  assign rd_done = (state_q == ARB_RD) && (cnt_q == RD_LAST);
  assign wr_done = (state_q == ARB_WR_HOLD);

  assign unused_addr_bits = ^{if_addr_i[31:SRAM_AW+2], if_addr_i[1:0],
                              mem_addr_i[31:SRAM_AW+2], mem_addr_i[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept_wr  = 1'b0;
    accept_mem = 1'b0;
    accept_if  = 1'b0;
    fetch_hit  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // MEM always wins; a fetch hitting the buffer completes without leaving IDLE.
        if (mem_wr) begin
          state_d   = ARB_WR_SETUP;
          accept_wr = 1'b1;
        end else if (mem_req) begin
          state_d    = ARB_RD;
          accept_mem = 1'b1;
        end else if (if_req_i) begin
          if (buf_hit) begin
            fetch_hit = 1'b1;
          end else begin
            state_d   = ARB_RD;
            accept_if = 1'b1;
          end
        end
      end
      ARB_RD: begin
        if (cnt_q == RD_LAST) begin
          state_d = ARB_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ARB_WR_SETUP: state_d = ARB_WR_PULSE;
      ARB_WR_PULSE: begin
        if (cnt_q == WR_LAST) begin
          state_d = ARB_WR_HOLD;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ARB_WR_HOLD: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= 3'd0;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= CTRL_OFF;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if (accept_wr) begin
        owner_q <= OWN_MEM;
        addr_q  <= mem_addr_i[SRAM_AW+1:2];
        wdata_q <= mem_wdata_i;
        be_q    <= mem_be_n_i;
      end else if (accept_mem) begin
        owner_q <= OWN_MEM;
        addr_q  <= mem_addr_i[SRAM_AW+1:2];
        be_q    <= mem_be_n_i;
      end else if (accept_if) begin
        owner_q <= OWN_IF;
        addr_q  <= if_addr_i[SRAM_AW+1:2];
        be_q    <= 4'b0000;
      end
      if (fetch_hit) begin
        if_ready_q <= 1'b1;
        if_data_q  <= buf_data;
      end
      if (rd_done) begin
        if (owner_q == OWN_MEM) begin
          mem_rdata_q <= sram_rdata_i;
          mem_ready_q <= 1'b1;
        end else begin
          if_data_q  <= sram_rdata_i;
          if_ready_q <= 1'b1;
        end
      end
      if (wr_done) mem_ready_q <= 1'b1;
    end
  end

`ifdef SRAM_ARB_FETCH_BUF_EN
  logic [29:0] fetch_tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            fetch_tag_q <= '0;
    else if (accept_if) fetch_tag_q <= if_addr_i[31:2];
  end

  sram_fetch_buf u_fetch_buf (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (if_addr_i[31:2]),
    .fill_en    (rd_done && (owner_q == OWN_IF)),
    .fill_tag   (fetch_tag_q),
    .fill_data  (sram_rdata_i),
    .inval_en   (accept_wr),
    .inval_tag  (mem_addr_i[31:2]),
    .hit        (buf_hit),
    .data       (buf_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  // SRAM strobes decode straight from the registered state, so reset clears them at once.
  assign sram_addr_o    = addr_q;
  assign sram_wdata_o   = wdata_q;
  assign sram_ce_n_o    = (state_q == ARB_IDLE);
  assign sram_oe_n_o    = (state_q != ARB_RD);
  assign sram_we_n_o    = (state_q != ARB_WR_PULSE);
  assign sram_data_oe_o = (state_q == ARB_WR_SETUP) || (state_q == ARB_WR_PULSE) ||
                          (state_q == ARB_WR_HOLD);
  assign sram_be_n_o    = (state_q == ARB_IDLE) ? CTRL_OFF : be_q;

  assign if_data_o   = if_data_q;
  assign if_ready_o  = if_ready_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_ready_o = mem_ready_q;
  assign stall_req_o = (mem_req && !mem_ready_q) || (if_req_i && !if_ready_q);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a byte-enabled SRAM model.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  logic        clk, rst;
  logic        if_req;
  logic [31:0] if_addr, if_data;
  logic        if_ready;
  logic        mem_ce_n, mem_we_n, mem_oe_n;
  logic [3:0]  mem_be_n;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, stall;
  logic [19:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;
  logic [7:0]  ctrl;

  int checks;
  int errors;

  logic [31:0] sram_mem [0:1023];
  logic        pre_en;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  sram_arbiter #(.RD_CYCLES(2), .WR_CYCLES(2), .SRAM_AW(20)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_ready_o(if_ready),
    .mem_ce_n_i(mem_ce_n), .mem_we_n_i(mem_we_n), .mem_oe_n_i(mem_oe_n), .mem_be_n_i(mem_be_n),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata),
    .mem_ready_o(mem_ready), .stall_req_o(stall),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
    .sram_data_oe_o(sram_data_oe), .sram_ce_n_o(sram_ce_n), .sram_oe_n_o(sram_oe_n),
    .sram_we_n_o(sram_we_n), .sram_be_n_o(sram_be_n)
  );

  // {ce_n, oe_n, we_n, data_oe, be_n}: idle = 8'hEF
  assign ctrl       = {sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, sram_be_n};
  assign sram_rdata = sram_mem[sram_addr[9:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pre_en) sram_mem[pre_addr] <= pre_data;
    else if (!sram_ce_n && !sram_we_n)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) sram_mem[sram_addr[9:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  task automatic mem_idle();
    mem_ce_n = 1'b1; mem_we_n = 1'b1; mem_oe_n = 1'b1; mem_be_n = 4'b1111;
  endtask

  task automatic test_reset();
    checks++; if (ctrl !== 8'hEF) begin errors++; $display("FAIL rst_ctrl got %h exp ef", ctrl); end
    checks++; if (sram_addr !== 20'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", sram_addr); end
    checks++; if (sram_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", sram_wdata); end
    checks++; if ({if_data, mem_rdata} !== 64'h0) begin errors++; $display("FAIL rst_data got %h %h exp 0 0", if_data, mem_rdata); end
    checks++; if ({if_ready, mem_ready, stall} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b exp 000", {if_ready, mem_ready, stall}); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (dut.state_q !== ARB_IDLE) begin errors++; $display("FAIL rst_state got %0d exp 0", dut.state_q); end
  endtask

  task automatic test_if_fetch();
    if_req = 1'b1; if_addr = 32'h8000_0010;
    #1;
    checks++; if ({stall, if_ready} !== 2'b10) begin errors++; $display("FAIL fetch_c0 stall/ready got %b exp 10", {stall, if_ready}); end
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++; if (ctrl !== 8'h20) begin errors++; $display("FAIL fetch_ctrl c%0d got %h exp 20", c, ctrl); end
      checks++; if (sram_addr !== 20'h00004) begin errors++; $display("FAIL fetch_addr c%0d got %h exp 00004", c, sram_addr); end
      checks++; if ({stall, if_ready} !== 2'b10) begin errors++; $display("FAIL fetch_stall c%0d got %b exp 10", c, {stall, if_ready}); end
    end
    tick();
    checks++; if ({stall, if_ready} !== 2'b01) begin errors++; $display("FAIL fetch_c3 stall/ready got %b exp 01", {stall, if_ready}); end
    checks++; if (if_data !== 32'h2402_0005) begin errors++; $display("FAIL fetch_data got %h exp 24020005", if_data); end
    checks++; if (ctrl !== 8'hEF) begin errors++; $display("FAIL fetch_idle_ctrl got %h exp ef", ctrl); end
    if_req = 1'b0;
    tick();
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL fetch_pulse_width got %b exp 0", if_ready); end
    checks++; if (if_data !== 32'h2402_0005) begin errors++; $display("FAIL fetch_hold got %h exp 24020005", if_data); end
  endtask

  task automatic test_store_byte();
    int we_low;
    logic [7:0] exp_ctrl;
    we_low = 0;
    mem_ce_n = 1'b0; mem_we_n = 1'b0; mem_oe_n = 1'b1; mem_be_n = 4'b1011;
    mem_addr = 32'h8000_0102; mem_wdata = 32'h5A5A_5A5A;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (!sram_we_n) we_low++;
      exp_ctrl = (c == 1 || c == 4) ? 8'h7B : 8'h5B;
      checks++; if (ctrl !== exp_ctrl) begin errors++; $display("FAIL store_ctrl c%0d got %h exp %h", c, ctrl, exp_ctrl); end
      checks++; if ({stall, mem_ready} !== 2'b10) begin errors++; $display("FAIL store_stall c%0d got %b exp 10", c, {stall, mem_ready}); end
    end
    checks++; if ({sram_addr, sram_wdata} !== {20'h00040, 32'h5A5A_5A5A}) begin errors++; $display("FAIL store_addr_wdata got %h %h exp 00040 5a5a5a5a", sram_addr, sram_wdata); end
    tick();
    checks++; if ({stall, mem_ready} !== 2'b01) begin errors++; $display("FAIL store_c5 stall/ready got %b exp 01", {stall, mem_ready}); end
    checks++; if (we_low !== 2) begin errors++; $display("FAIL store_we_width got %0d exp 2", we_low); end
    mem_idle();
    tick();
    checks++; if (sram_mem[10'h040] !== 32'h115A_3344) begin errors++; $display("FAIL store_byte_merge got %h exp 115a3344", sram_mem[10'h040]); end
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h8000_0030;
    mem_ce_n = 1'b0; mem_we_n = 1'b1; mem_oe_n = 1'b0; mem_be_n = 4'b0011; mem_addr = 32'h8000_0020;
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++; if ({ctrl, sram_addr} !== {8'h23, 20'h00008}) begin errors++; $display("FAIL simul_mem c%0d got %h %h exp 23 00008", c, ctrl, sram_addr); end
    end
    tick();
    checks++; if ({mem_ready, if_ready, stall} !== 3'b101) begin errors++; $display("FAIL simul_c3 got %b exp 101", {mem_ready, if_ready, stall}); end
    checks++; if (mem_rdata !== 32'hAAAA_0008) begin errors++; $display("FAIL simul_mem_data got %h exp aaaa0008", mem_rdata); end
    mem_idle();
    for (int c = 4; c <= 5; c++) begin
      tick();
      checks++; if ({ctrl, sram_addr, stall} !== {8'h20, 20'h0000C, 1'b1}) begin errors++; $display("FAIL simul_if c%0d got %h %h %b exp 20 0000c 1", c, ctrl, sram_addr, stall); end
    end
    tick();
    checks++; if ({if_ready, stall} !== 2'b10) begin errors++; $display("FAIL simul_c6 got %b exp 10", {if_ready, stall}); end
    checks++; if (if_data !== 32'hBBBB_000C) begin errors++; $display("FAIL simul_if_data got %h exp bbbb000c", if_data); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_load_after_store();
    mem_ce_n = 1'b0; mem_we_n = 1'b0; mem_oe_n = 1'b0; mem_be_n = 4'b0000;
    mem_addr = 32'h8000_0200; mem_wdata = 32'hDEAD_BEEF;
    tick();
    checks++; if (ctrl !== 8'h70) begin errors++; $display("FAIL las_both_low_is_write got %h exp 70", ctrl); end
    repeat (4) tick();
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL las_write_ready got %b exp 1", mem_ready); end
    mem_idle();
    tick();
    mem_ce_n = 1'b0; mem_oe_n = 1'b0; mem_be_n = 4'b0000; mem_addr = 32'h8000_0200;
    repeat (3) tick();
    checks++; if ({mem_ready, mem_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL las_load got %b %h exp 1 deadbeef", mem_ready, mem_rdata); end
    mem_idle();
    tick();
    checks++; if ({mem_ready, mem_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin errors++; $display("FAIL las_hold got %b %h exp 0 deadbeef", mem_ready, mem_rdata); end
  endtask

  task automatic test_drop_mid();
    if_req = 1'b1; if_addr = 32'h8000_0020;
    tick();
    if_req = 1'b0;
    #1;
    checks++; if ({ctrl, stall} !== {8'h20, 1'b0}) begin errors++; $display("FAIL drop_c1 got %h %b exp 20 0", ctrl, stall); end
    repeat (2) tick();
    checks++; if ({if_ready, if_data} !== {1'b1, 32'hAAAA_0008}) begin errors++; $display("FAIL drop_ready got %b %h exp 1 aaaa0008", if_ready, if_data); end
    tick();
  endtask

  task automatic test_fetch_buf();
    if_req = 1'b1; if_addr = 32'h8000_0010;
    repeat (3) tick();
    checks++; if ({if_ready, if_data} !== {1'b1, 32'h2402_0005}) begin errors++; $display("FAIL fbuf_first got %b %h exp 1 24020005", if_ready, if_data); end
    if_req = 1'b0;
    tick();
    if_req = 1'b1;
    tick();
`ifdef SRAM_ARB_FETCH_BUF_EN
    checks++; if ({if_ready, if_data, ctrl} !== {1'b1, 32'h2402_0005, 8'hEF}) begin errors++; $display("FAIL fbuf_hit got %b %h %h exp 1 24020005 ef", if_ready, if_data, ctrl); end
    if_req = 1'b0;
    tick();
    checks++; if (ctrl !== 8'hEF) begin errors++; $display("FAIL fbuf_no_sram got %h exp ef", ctrl); end
`else
    checks++; if ({if_ready, ctrl} !== {1'b0, 8'h20}) begin errors++; $display("FAIL fbuf_off_sram got %b %h exp 0 20", if_ready, ctrl); end
    repeat (2) tick();
    checks++; if ({if_ready, if_data} !== {1'b1, 32'h2402_0005}) begin errors++; $display("FAIL fbuf_off_second got %b %h exp 1 24020005", if_ready, if_data); end
    if_req = 1'b0;
    tick();
`endif
    mem_ce_n = 1'b0; mem_we_n = 1'b0; mem_be_n = 4'b0000;
    mem_addr = 32'h8000_0010; mem_wdata = 32'h1234_5678;
    repeat (5) tick();
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL fbuf_store_ready got %b exp 1", mem_ready); end
    mem_idle();
    tick();
    if_req = 1'b1;
    tick();
    checks++; if (ctrl !== 8'h20) begin errors++; $display("FAIL fbuf_refetch_sram got %h exp 20", ctrl); end
    repeat (2) tick();
    checks++; if ({if_ready, if_data} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL fbuf_refetch_data got %b %h exp 1 12345678", if_ready, if_data); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    mem_ce_n = 1'b0; mem_we_n = 1'b0; mem_oe_n = 1'b1; mem_be_n = 4'b0000;
    mem_addr = 32'h8000_0400; mem_wdata = 32'hCAFE_F00D;
    repeat (2) tick();
    checks++; if (ctrl !== 8'h50) begin errors++; $display("FAIL rstmid_pulse got %h exp 50", ctrl); end
    rst = 1'b1;
    #1;
    checks++; if (ctrl !== 8'hEF) begin errors++; $display("FAIL rstmid_ctrl got %h exp ef", ctrl); end
    checks++; if ({sram_addr, sram_wdata, mem_ready} !== 53'h0) begin errors++; $display("FAIL rstmid_regs got %h %h %b exp 0 0 0", sram_addr, sram_wdata, mem_ready); end
    mem_idle();
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({dut.state_q, ctrl, mem_ready} !== {ARB_IDLE, 8'hEF, 1'b0}) begin errors++; $display("FAIL rstmid_after got %0d %h %b exp 0 ef 0", dut.state_q, ctrl, mem_ready); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    if_req = 1'b0; if_addr = '0; mem_addr = '0; mem_wdata = '0;
    mem_idle();
    preload(10'h004, 32'h2402_0005);
    preload(10'h040, 32'h1122_3344);
    preload(10'h008, 32'hAAAA_0008);
    preload(10'h00C, 32'hBBBB_000C);
    test_reset();
    test_if_fetch();
    test_store_byte();
    test_simultaneous();
    test_load_after_store();
    test_drop_mid();
    test_fetch_buf();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 32-bit base SRAM between the instruction-fetch (IF) port and the MEM-stage load/store port.
- Sequences multi-cycle SRAM read and write timing, and registers the returned data.
- Raises a pipeline stall request until each pending access completes.
- Sits between the IF/MEM pipeline stages and the SRAM pins; decodes the MEM stage's active-low ce/we/oe/be controls.

Parameters:
RD_CYCLES, 2, cycles oe_n is held low before read data is sampled (1..7)
WR_CYCLES, 2, cycles we_n is held low during a write pulse (1..7)
SRAM_AW, 20, SRAM word-address width

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
if_req_i  in  1  fetch request (level)
if_addr_i  in  32  fetch byte address (word aligned)
if_data_o  out  32  fetched instruction, valid when if_ready_o=1
if_ready_o  out  1  one-cycle pulse: fetch complete
mem_ce_n_i  in  1  MEM access enable, active low
mem_we_n_i  in  1  MEM write, active low
mem_oe_n_i  in  1  MEM read, active low
mem_be_n_i  in  4  MEM byte enables, active low
mem_addr_i  in  32  MEM byte address
mem_wdata_i  in  32  store data
mem_rdata_o  out  32  load data, valid when mem_ready_o=1
mem_ready_o  out  1  one-cycle pulse: MEM access complete
stall_req_o  out  1  pipeline stall request
sram_addr_o  out  SRAM_AW  SRAM word address = addr[SRAM_AW+1:2]
sram_wdata_o  out  32  SRAM write data
sram_rdata_i  in  32  SRAM read data
sram_data_oe_o  out  1  drive the data bus (1 = write)
sram_ce_n_o  out  1  SRAM chip enable, active low
sram_oe_n_o  out  1  SRAM output enable, active low
sram_we_n_o  out  1  SRAM write enable, active low
sram_be_n_o  out  4  SRAM byte enables, active low

Behaviour:
- Reset:
  - state=IDLE.
  - sram_ce_n/oe_n/we_n=1, sram_be_n=4'b1111, sram_data_oe=0, sram_addr/wdata=0.
  - if_data_o/mem_rdata_o=0, ready pulses=0, counter=0.
- Reset is asynchronous: asserting it mid-access returns all outputs to their reset values in the same cycle; the interrupted access is lost.
- MEM request = mem_ce_n_i==0 && (mem_we_n_i==0 || mem_oe_n_i==0).
- If both mem_we_n_i and mem_oe_n_i are low, the access is treated as a write.
- FSM states:
  - IDLE
    - MEM write request -> WR_SETUP.
    - Else MEM read request -> RD with owner=MEM.
    - Else if_req_i -> RD with owner=IF.
    - MEM has strict priority over IF.
  - RD
    - ce_n=0, oe_n=0; be_n = mem_be_n_i when owner=MEM, else 4'b0000.
    - Address and be are latched on entry.
    - After RD_CYCLES cycles, sample sram_rdata_i into the owner's data register, pulse the owner's ready for 1 cycle, -> IDLE.
  - WR_SETUP
    - 1 cycle: ce_n=0, data_oe=1, we_n=1.
    - Address, data and be are latched on entry.
  - WR_PULSE
    - we_n=0 for WR_CYCLES cycles.
  - WR_HOLD
    - 1 cycle: we_n=1, data_oe=1, ce_n=0.
    - Then pulse mem_ready_o, -> IDLE.
- Latency from request to ready:
  - Read: RD_CYCLES+1 cycles.
  - Write: WR_CYCLES+3 cycles.
- Back-to-back accesses: at least one IDLE cycle between accesses; the IDLE cycle re-arbitrates.
- stall_req_o is combinational: (MEM request && !mem_ready_o) || (if_req_i && !if_ready_o).
- Data registers hold their value until the next completion for the same port.
- A request deasserted mid-access: the access completes normally and the ready pulse is still issued.
- A new request is accepted only in IDLE.
- sram_addr_o ignores addr[1:0]. Byte selection comes only from be.

Optional Feature:
- Macro: SRAM_ARB_FETCH_BUF_EN.
- Defined:
  - Add a one-entry fetch buffer {valid, tag=if_addr[31:2], data}.
  - In IDLE, if_req_i with a tag hit and no MEM request -> if_ready_o pulses next cycle with buffered data; no SRAM cycle.
  - Every IF read fills the buffer.
  - Any MEM write whose word address equals the tag clears valid.
  - Reset clears valid.
- Undefined: every fetch goes to SRAM.

Decomposition:
- Shared package holds:
  - State encoding constants: ARB_IDLE, ARB_RD, ARB_WR_SETUP, ARB_WR_PULSE, ARB_WR_HOLD.
  - Owner constants: OWN_IF, OWN_MEM.
  - Inactive-control constant 4'b1111.
- One sub-module: sram_fetch_buf, which holds the tag/valid/data compare; present only under the macro.

Test Plan:
- Reset: assert rst mid-WR_PULSE -> same cycle sram_we_n_o=1, sram_ce_n_o=1, sram_data_oe_o=0; after release, state=IDLE.
- IF fetch: if_req_i=1, if_addr_i=0x8000_0010, SRAM word 4 = 0x2402_0005, RD_CYCLES=2 -> sram_addr_o=0x00004, if_ready_o pulses at cycle 3 with if_data_o=0x2402_0005; stall_req_o=1 for cycles 0-2.
- Store byte: mem_ce_n=0, we_n=0, be_n=4'b1011, addr=0x8000_0102, wdata=0x5A5A_5A5A -> sram_be_n_o=4'b1011, we_n low exactly 2 cycles, mem_ready_o at cycle 5.
- Simultaneous: IF and MEM read requests in the same cycle -> MEM served first; IF served after one IDLE cycle; stall_req_o stays high until if_ready_o.
- Load after store: write 0xDEAD_BEEF to 0x8000_0200, then load from 0x8000_0200 with be_n=0000 -> mem_rdata_o=0xDEAD_BEEF.
- Fetch buffer (macro on): fetch 0x8000_0010 twice -> second fetch produces no sram_ce_n_o low and if_ready_o after 1 cycle; then store to 0x8000_0010 and re-fetch -> SRAM read occurs and returns the new data.
